rv_byte_loader: RTL and testbench

//  Upstream program-load stage for the riscv32i core: accepts a byte stream

---
 rtl/rv_loader_pkg.sv | 22 ++
 rtl/rv_byte_loader_if.sv | 31 +++
 rtl/rv_loader_fifo.sv | 87 ++++++++
 rtl/rv_byte_loader.sv | 110 +++++++++++
 tb/tb_rv_byte_loader.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/rv_loader_pkg.sv
// ============================================================================
// Module      : rv_loader_pkg
// Description : Shared constants for the riscv32i byte-stream program loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);
    localparam int ASM_W          = (BYTES_PER_WORD - 1) * BYTE_W;

    localparam logic [BYTE_W-1:0] RST_CHK  = '0;
    localparam logic [LANE_W-1:0] RST_LANE = '0;
    localparam logic [WORD_W-1:0] RST_WORD = '0;

endpackage : rv_loader_pkg

`default_nettype wire

// File: rtl/rv_byte_loader_if.sv
// ============================================================================
// Module      : rv_byte_loader_if
// Description : Byte-in / word-out handshake bundle of the program loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rv_byte_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [31:0]       word_data;
    logic [ADDR_W-1:0] word_addr;
    logic              word_valid;
    logic              word_ready;

    // master = byte producer and word consumer; slave = the loader itself
    modport master (
        output byte_in, byte_valid, word_ready,
        input  byte_ready, word_data, word_addr, word_valid
    );

    modport slave (
        input  byte_in, byte_valid, word_ready,
        output byte_ready, word_data, word_addr, word_valid
    );
endinterface : rv_byte_loader_if

`default_nettype wire

// File: rtl/rv_loader_fifo.sv
// ============================================================================
// Module      : rv_loader_fifo
// Description : Synchronous word+address FIFO with flush and registered head.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_loader_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              flush,
    input  wire logic              push,
    input  wire logic [DATA_W-1:0] push_data,
    input  wire logic [ADDR_W-1:0] push_addr,
    input  wire logic              pop,
    output logic                   full,
    output logic                   empty,
    output logic [DATA_W-1:0]      head_data,
    output logic [ADDR_W-1:0]      head_addr
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

    logic [DATA_W-1:0]  r_mem_data [DEPTH];
    logic [ADDR_W-1:0]  r_mem_addr [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic               w_push;
    logic               w_pop;
    logic [c_ptr_w-1:0] w_rd_next;
    logic [c_cnt_w-1:0] w_remain;
    logic [c_cnt_w-1:0] w_cnt_next;

    assign full       = (r_count == c_full);
    assign empty      = (r_count == '0);
    assign w_push     = push & ~full;
    assign w_pop      = pop & ~empty;
    assign w_rd_next  = r_rd_ptr + c_ptr_w'(w_pop);
    assign w_remain   = r_count - c_cnt_w'(w_pop);
    assign w_cnt_next = w_remain + c_cnt_w'(w_push);

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem_data[r_wr_ptr] <= push_data;
            r_mem_addr[r_wr_ptr] <= push_addr;
        end
    end

    // Head is preloaded with the next entry so it never depends on the array
    // read combinationally; it keeps its last value once the FIFO drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            head_data <= '0;
            head_addr <= '0;
        end else if (flush) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
        end else begin
            r_rd_ptr <= w_rd_next;
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(w_push);
            r_count  <= w_cnt_next;
            if (w_cnt_next != '0) begin
                if (w_remain == '0) begin
                    head_data <= push_data;
                    head_addr <= push_addr;
                end else begin
                    head_data <= r_mem_data[w_rd_next];
                    head_addr <= r_mem_addr[w_rd_next];
                end
            end
        end
    end

endmodule : rv_loader_fifo

`default_nettype wire

// File: rtl/rv_byte_loader.sv
// ============================================================================
// Module      : rv_byte_loader
// Description : Assembles little-endian 32-bit words from a byte stream, tags
//               them with a word address and buffers them for the core.
//               Optional running XOR checksum under LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_byte_loader
    import rv_loader_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         load_start,
    rv_byte_loader_if.slave   bus,
    output logic              addr_wrap,
    output logic [BYTE_W-1:0] chk_out
);
    logic [LANE_W-1:0] r_byte_cnt;
    logic [ASM_W-1:0]  r_asm;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wrap;

    logic              w_full;
    logic              w_empty;
    logic              w_last;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [WORD_W-1:0] w_word;

    // byte_ready depends only on registered state, never on word_ready
    assign w_last         = (r_byte_cnt == LANE_W'(BYTES_PER_WORD - 1));
    assign bus.byte_ready = ~(w_full & w_last);
    assign w_accept       = bus.byte_valid & bus.byte_ready & ~load_start;
    assign w_push         = w_accept & w_last;
    assign w_pop          = ~w_empty & bus.word_ready & ~load_start;
    assign w_word         = {bus.byte_in, r_asm};
    assign bus.word_valid = ~w_empty;
    assign addr_wrap      = r_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt <= RST_LANE;
            r_asm      <= '0;
            r_addr     <= '0;
            r_wrap     <= 1'b0;
        end else if (load_start) begin
            r_byte_cnt <= RST_LANE;
            r_addr     <= '0;
            r_wrap     <= 1'b0;
        end else if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
            for (int i = 0; i < BYTES_PER_WORD - 1; i++) begin
                if (r_byte_cnt == LANE_W'(i)) begin
                    r_asm[i*BYTE_W +: BYTE_W] <= bus.byte_in;
                end
            end
            if (w_push) begin
                r_addr <= r_addr + 1'b1;
                if (&r_addr) begin
                    r_wrap <= 1'b1;
                end
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] r_chk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chk <= RST_CHK;
        end else if (load_start) begin
            r_chk <= RST_CHK;
        end else if (w_accept) begin
            r_chk <= r_chk ^ bus.byte_in;
        end
    end

    assign chk_out = r_chk;
`else
    assign chk_out = RST_CHK;
`endif

    rv_loader_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (load_start),
        .push      (w_push),
        .push_data (w_word),
        .push_addr (r_addr),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head_data (bus.word_data),
        .head_addr (bus.word_addr)
    );

endmodule : rv_byte_loader

`default_nettype wire

// File: tb/tb_rv_byte_loader.sv
// ============================================================================
// Module      : tb_rv_byte_loader
// Description : Directed self-checking bench; a second instance with a 2-bit
//               address counter exercises wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_byte_loader;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_start = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       word_ready = 1'b0;
    logic       wrap8, wrap2;
    logic [7:0] chk8, chk2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [39:0] q8[$];
    logic [39:0] q2[$];

    rv_byte_loader_if #(.ADDR_W(8)) bus8 ();
    rv_byte_loader_if #(.ADDR_W(2)) bus2 ();

    assign bus8.byte_in    = byte_in;
    assign bus8.byte_valid = byte_valid;
    assign bus8.word_ready = word_ready;
    assign bus2.byte_in    = byte_in;
    assign bus2.byte_valid = byte_valid;
    assign bus2.word_ready = word_ready;

    rv_byte_loader #(.FIFO_DEPTH(4), .ADDR_W(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .bus        (bus8.slave),
        .addr_wrap  (wrap8),
        .chk_out    (chk8)
    );

    rv_byte_loader #(.FIFO_DEPTH(4), .ADDR_W(2)) u_dut_w (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .bus        (bus2.slave),
        .addr_wrap  (wrap2),
        .chk_out    (chk2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && word_ready && !load_start) begin
            if (bus8.word_valid) q8.push_back({bus8.word_addr, bus8.word_data});
            if (bus2.word_valid) q2.push_back({6'b0, bus2.word_addr, bus2.word_data});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        check("byte_ready_on_put", 64'(bus8.byte_ready), 64'd1);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_word_valid"}, 64'(bus8.word_valid), 64'd0);
        check({tag, "_byte_ready"}, 64'(bus8.byte_ready), 64'd1);
        check({tag, "_word_data"},  64'(bus8.word_data),  64'd0);
        check({tag, "_word_addr"},  64'(bus8.word_addr),  64'd0);
        check({tag, "_addr_wrap"},  64'(wrap8),           64'd0);
        check({tag, "_chk_out"},    64'(chk8),            64'd0);
    endtask

    initial begin
        logic [7:0] exp_chk;

        // 1: reset values and two streamed words
        #3;
        check_reset_outputs("rst");
        tick();
        rst_n = 1'b1;
        tick();
        check_reset_outputs("post_rst");
        word_ready = 1'b1;
        put_byte(8'h78); put_byte(8'h56); put_byte(8'h34); put_byte(8'h12);
        put_byte(8'h21); put_byte(8'h43); put_byte(8'h65); put_byte(8'h87);
        tick(); tick();
        check("t1_count", 64'(q8.size()), 64'd2);
        check("t1_word0", 64'(q8[0]), {24'h0, 8'h00, 32'h12345678});
        check("t1_word1", 64'(q8[1]), {24'h0, 8'h01, 32'h87654321});

        // 2+5: fill FIFO, stall 4th byte, pop-with-stall, refill to full
        load_start = 1'b1; tick(); load_start = 1'b0;
        q8.delete();
        word_ready = 1'b0;
        for (int i = 0; i < 19; i++) put_byte(8'(i));
        byte_valid = 1'b1; byte_in = 8'd19;
        check("t2_stall_ready", 64'(bus8.byte_ready), 64'd0);
        tick();
        check("t2_stall_ready_held", 64'(bus8.byte_ready), 64'd0);
        check("t2_head_data", 64'(bus8.word_data), 64'h03020100);
        check("t2_head_addr", 64'(bus8.word_addr), 64'd0);
        word_ready = 1'b1;
        check("t5_no_comb_ready", 64'(bus8.byte_ready), 64'd0);
        tick();
        word_ready = 1'b0;
        check("t5_ready_after_pop", 64'(bus8.byte_ready), 64'd1);
        check("t5_head_data", 64'(bus8.word_data), 64'h07060504);
        check("t5_head_addr", 64'(bus8.word_addr), 64'd1);
        tick();
        byte_valid = 1'b0;
        put_byte(8'd20); put_byte(8'd21); put_byte(8'd22);
        byte_valid = 1'b1; byte_in = 8'd23;
        check("t5_full_again", 64'(bus8.byte_ready), 64'd0);
        word_ready = 1'b1;
        tick(); tick();
        byte_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("t2_count", 64'(q8.size()), 64'd6);
        for (int k = 0; k < 6; k++) begin
            logic [31:0] w;
            w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            check($sformatf("t2_word%0d", k), 64'(q8[k]), {24'h0, 8'(k), w});
        end
        check("t2_wrap2_set", 64'(wrap2), 64'd1);

        // 3: load_start drops partial word and the buffered word, ignores pop
        load_start = 1'b1; tick(); load_start = 1'b0;
        word_ready = 1'b0;
        q8.delete();
        put_byte(8'hDE); put_byte(8'hAD); put_byte(8'hBE); put_byte(8'hEF);
        put_byte(8'hAA); put_byte(8'hBB);
        check("t3_buffered", 64'(bus8.word_valid), 64'd1);
        load_start = 1'b1; byte_valid = 1'b1; byte_in = 8'hCC; word_ready = 1'b1;
        tick();
        load_start = 1'b0; byte_valid = 1'b0;
        check("t3_flushed", 64'(bus8.word_valid), 64'd0);
        check("t3_no_pop", 64'(q8.size()), 64'd0);
        check("t3_wrap2_clr", 64'(wrap2), 64'd0);
        check("t3_chk_clr", 64'(chk8), 64'd0);
        put_byte(8'h11); put_byte(8'h22); put_byte(8'h33); put_byte(8'h44);
        tick(); tick();
        check("t3_count", 64'(q8.size()), 64'd1);
        check("t3_word", 64'(q8[0]), {24'h0, 8'h00, 32'h44332211});

        // 6: checksum and async reset mid-word
        load_start = 1'b1; tick(); load_start = 1'b0;
        exp_chk = 8'h00;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = 8'(1 << i);
            exp_chk = exp_chk ^ b;
            put_byte(b);
            check($sformatf("t6_chk%0d", i), 64'(chk8), CHK_EN ? 64'(exp_chk) : 64'd0);
        end
        word_ready = 1'b0;
        put_byte(8'hA0); put_byte(8'hA1); put_byte(8'hA2); put_byte(8'hA3);
        put_byte(8'hB0); put_byte(8'hB1);
        check("t6_pre_rst_valid", 64'(bus8.word_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check_reset_outputs("t6_post_rst");

        // 4: 2-bit address counter wraps after the 4th push
        q2.delete();
        word_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++) put_byte(8'(4*k+j));
            check($sformatf("t4_wrap_after%0d", k), 64'(wrap2), (k >= 3) ? 64'd1 : 64'd0);
        end
        tick(); tick();
        check("t4_count", 64'(q2.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t4_addr%0d", k), 64'(q2[k][39:32]), 64'(k % 4));
        end
        check("t4_data4", 64'(q2[4][31:0]), 64'h13121110);
        check("t4_wrap8_clear", 64'(wrap8), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rv_byte_loader

`default_nettype wire
